// File: rtl/max7219_rx_pkg.sv
// Shared constants and types for the MAX7219 serial-link receiver.
// Register addresses match the ones the display driver emits.
package max7219_rx_pkg;

   localparam int unsigned FRAME_W = 16;
   localparam int unsigned CNT_W   = 5;

   localparam logic [3:0] REG_NOOP      = 4'h0;
   localparam logic [3:0] REG_DIGIT0    = 4'h1;
   localparam logic [3:0] REG_DECODE    = 4'h9;
   localparam logic [3:0] REG_INTENSITY = 4'hA;
   localparam logic [3:0] REG_SCANLIM   = 4'hB;
   localparam logic [3:0] REG_SHUTDOWN  = 4'hC;
   localparam logic [3:0] REG_TEST      = 4'hF;

   typedef enum logic [1:0] {
      StWaitIdle,
      StIdle,
      StShift
   } rx_state_e;

endpackage

// File: rtl/max7219_rx_sync_edge.sv
// N-flop synchronizer for an asynchronous level, plus one-cycle rise/fall pulses
// derived from the synchronized value.
module max7219_rx_sync_edge #(
   parameter int unsigned STAGES = 2
) (
   input  logic clock,
   input  logic reset,
   input  logic async_in,
   output logic sync,
   output logic rise,
   output logic fall
);

   logic [STAGES-1:0] sync_q;
   logic              last_q;

   always_ff @(posedge clock) begin
      if (!reset) begin
         sync_q <= '0;
         last_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], async_in};
         last_q <= sync_q[STAGES-1];
      end
   end

   assign sync = sync_q[STAGES-1];
   assign rise = sync & ~last_q;
   assign fall = ~sync & last_q;

endmodule

// File: rtl/max7219_rx.sv
// Receive-side decoder for the MAX7219 sck/cs/din link: reassembles 16-bit frames
// and keeps a shadow copy of the MAX7219 register file.
module max7219_rx
   import max7219_rx_pkg::*;
#(
   parameter int unsigned DIGIT_NUM   = 8,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   sck,
   input  logic                   cs,
   input  logic                   din,
   output logic                   frame_valid,
   output logic [3:0]             frame_addr,
   output logic [7:0]             frame_data,
   output logic                   frame_err,
   output logic                   busy,
   output logic [DIGIT_NUM*8-1:0] digits,
   output logic [7:0]             decode_mode,
   output logic [3:0]             intensity,
   output logic [2:0]             scan_limit,
   output logic                   shutdown_n,
   output logic                   display_test
);

   logic sck_s, sck_rise, sck_fall;
   logic cs_s, cs_rise, cs_fall;
   logic [SYNC_STAGES-1:0] din_sync_q;
   logic din_s;

   max7219_rx_sync_edge #(.STAGES(SYNC_STAGES)) u_sck_sync (
      .clock    (clock),
      .reset    (reset),
      .async_in (sck),
      .sync     (sck_s),
      .rise     (sck_rise),
      .fall     (sck_fall)
   );

   max7219_rx_sync_edge #(.STAGES(SYNC_STAGES)) u_cs_sync (
      .clock    (clock),
      .reset    (reset),
      .async_in (cs),
      .sync     (cs_s),
      .rise     (cs_rise),
      .fall     (cs_fall)
   );

   assign din_s = din_sync_q[SYNC_STAGES-1];

   rx_state_e              state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [FRAME_W-1:0]     shift_q, shift_d;
   logic                   commit;
   logic                   valid_q, valid_d, err_q, err_d;
   logic [3:0]             addr_q, addr_d, intensity_q, intensity_d;
   logic [7:0]             data_q, data_d, decode_q, decode_d;
   logic [DIGIT_NUM*8-1:0] digits_q, digits_d;
   logic [2:0]             scan_q, scan_d;
   logic                   shutdown_q, shutdown_d, test_q, test_d;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      shift_d     = shift_q;
      commit      = 1'b0;
      err_d       = 1'b0;
      unique case (state_q)
         StWaitIdle: if (cs_s) state_d = StIdle;
         StIdle: begin
            if (cs_fall) begin
               state_d = StShift;
               cnt_d   = '0;
               shift_d = '0;
            end
         end
         StShift: begin
            // Shift before the length test so a bit landing with cs_rise still counts.
            if (sck_rise) begin
               shift_d = {shift_q[FRAME_W-2:0], din_s};
               if (cnt_q != CNT_W'(FRAME_W)) cnt_d = cnt_q + CNT_W'(1);
            end
            if (cs_rise) begin
               state_d = StIdle;
               if (cnt_d == CNT_W'(FRAME_W)) commit = 1'b1;
               else                          err_d  = 1'b1;
            end
         end
         default: state_d = StWaitIdle;
      endcase
   end

   always_comb begin
      valid_d     = commit;
      addr_d      = addr_q;
      data_d      = data_q;
      digits_d    = digits_q;
      decode_d    = decode_q;
      intensity_d = intensity_q;
      scan_d      = scan_q;
      shutdown_d  = shutdown_q;
      test_d      = test_q;
      if (commit) begin
         addr_d = shift_d[11:8];
         data_d = shift_d[7:0];
         case (shift_d[11:8])
            REG_NOOP:      ;
            REG_DECODE:    decode_d    = shift_d[7:0];
            REG_INTENSITY: intensity_d = shift_d[3:0];
            REG_SCANLIM:   scan_d      = shift_d[2:0];
            REG_SHUTDOWN:  shutdown_d  = shift_d[0];
            REG_TEST:      test_d      = shift_d[0];
            default: begin
               // Digit addresses beyond DIGIT_NUM (and 0xD/0xE) fall through unmatched.
               for (int k = 1; k <= DIGIT_NUM; k++) begin
                  if (shift_d[11:8] == REG_DIGIT0 + 4'(k - 1)) digits_d[8*k-1 -: 8] = shift_d[7:0];
               end
            end
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q     <= StWaitIdle;
         cnt_q       <= '0;
         shift_q     <= '0;
         din_sync_q  <= '0;
         valid_q     <= 1'b0;
         err_q       <= 1'b0;
         addr_q      <= '0;
         data_q      <= '0;
         digits_q    <= '0;
         decode_q    <= '0;
         intensity_q <= '0;
         scan_q      <= '0;
         shutdown_q  <= 1'b0;
         test_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         shift_q     <= shift_d;
         din_sync_q  <= {din_sync_q[SYNC_STAGES-2:0], din};
         valid_q     <= valid_d;
         err_q       <= err_d;
         addr_q      <= addr_d;
         data_q      <= data_d;
         digits_q    <= digits_d;
         decode_q    <= decode_d;
         intensity_q <= intensity_d;
         scan_q      <= scan_d;
         shutdown_q  <= shutdown_d;
         test_q      <= test_d;
      end
   end

   logic unused_sigs;
   assign unused_sigs = ^{shift_q[FRAME_W-1], sck_s, sck_fall};

   assign frame_valid  = valid_q;
   assign frame_err    = err_q;
   assign frame_addr   = addr_q;
   assign frame_data   = data_q;
   assign busy         = (state_q == StShift);
   assign digits       = digits_q;
   assign decode_mode  = decode_q;
   assign intensity    = intensity_q;
   assign scan_limit   = scan_q;
   assign shutdown_n   = shutdown_q;
   assign display_test = test_q;

endmodule

// File: tb/tb_max7219_rx.sv
// Bench for max7219_rx: an 8-digit and a 4-digit instance share one link and are
// compared against a register-file model after every frame.
module tb_max7219_rx;

   logic clock = 1'b0;
   logic reset = 1'b0;
   logic sck = 1'b0, cs = 1'b1, din = 1'b0;

   always #5 clock = ~clock;

   logic        fv8, fe8, busy8, shd8, tst8;
   logic [3:0]  fa8, int8;
   logic [7:0]  fd8, dec8;
   logic [2:0]  scan8;
   logic [63:0] dig8;
   logic        fv4, fe4, busy4, shd4, tst4;
   logic [3:0]  fa4, int4;
   logic [7:0]  fd4, dec4;
   logic [2:0]  scan4;
   logic [31:0] dig4;

   max7219_rx #(.DIGIT_NUM(8), .SYNC_STAGES(2)) dut8 (
      .clock(clock), .reset(reset), .sck(sck), .cs(cs), .din(din),
      .frame_valid(fv8), .frame_addr(fa8), .frame_data(fd8), .frame_err(fe8), .busy(busy8),
      .digits(dig8), .decode_mode(dec8), .intensity(int8), .scan_limit(scan8),
      .shutdown_n(shd8), .display_test(tst8)
   );

   max7219_rx #(.DIGIT_NUM(4), .SYNC_STAGES(2)) dut4 (
      .clock(clock), .reset(reset), .sck(sck), .cs(cs), .din(din),
      .frame_valid(fv4), .frame_addr(fa4), .frame_data(fd4), .frame_err(fe4), .busy(busy4),
      .digits(dig4), .decode_mode(dec4), .intensity(int4), .scan_limit(scan4),
      .shutdown_n(shd4), .display_test(tst4)
   );

   typedef struct {
      logic [63:0] digits;
      logic [7:0]  decode;
      logic [3:0]  intensity;
      logic [2:0]  scan;
      logic        shutdown;
      logic        test;
      logic [3:0]  addr;
      logic [7:0]  data;
   } model_t;

   typedef struct {
      logic [31:0] bits;
      int          n;
      int          exp_v;
      int          exp_e;
   } vec_t;

   model_t m8, m4;
   int exp_v = 0, exp_e = 0;
   int vcnt8 = 0, ecnt8 = 0, vcnt4 = 0, ecnt4 = 0, both_cnt = 0;
   int checks = 0, errors = 0;

   always @(negedge clock) begin
      if (fv8) vcnt8 <= vcnt8 + 1;
      if (fe8) ecnt8 <= ecnt8 + 1;
      if (fv4) vcnt4 <= vcnt4 + 1;
      if (fe4) ecnt4 <= ecnt4 + 1;
      if ((fv8 && fe8) || (fv4 && fe4)) both_cnt <= both_cnt + 1;
   end

   function automatic model_t apply(input model_t m, input logic [15:0] f, input int num);
      int a;
      a = int'(f[11:8]);
      m.addr = f[11:8];
      m.data = f[7:0];
      if (a >= 1 && a <= 8) begin
         if (a <= num) m.digits[(a-1)*8 +: 8] = f[7:0];
      end else if (a == 9)  m.decode    = f[7:0];
      else if (a == 10)     m.intensity = f[3:0];
      else if (a == 11)     m.scan      = f[2:0];
      else if (a == 12)     m.shutdown  = f[0];
      else if (a == 15)     m.test      = f[0];
      return m;
   endfunction

   task automatic model_frame(input logic [31:0] bits, input int n);
      if (n >= 16) begin
         m8 = apply(m8, bits[15:0], 8);
         m4 = apply(m4, bits[15:0], 4);
         exp_v++;
      end else begin
         exp_e++;
      end
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_state(input string tag);
      check({tag, ".valid8"}, 64'(vcnt8), 64'(exp_v));
      check({tag, ".err8"}, 64'(ecnt8), 64'(exp_e));
      check({tag, ".valid4"}, 64'(vcnt4), 64'(exp_v));
      check({tag, ".err4"}, 64'(ecnt4), 64'(exp_e));
      check({tag, ".busy8"}, 64'(busy8), 64'd0);
      check({tag, ".addr8"}, 64'(fa8), 64'(m8.addr));
      check({tag, ".data8"}, 64'(fd8), 64'(m8.data));
      check({tag, ".digits8"}, dig8, m8.digits);
      check({tag, ".decode8"}, 64'(dec8), 64'(m8.decode));
      check({tag, ".intensity8"}, 64'(int8), 64'(m8.intensity));
      check({tag, ".scan8"}, 64'(scan8), 64'(m8.scan));
      check({tag, ".shutdown8"}, 64'(shd8), 64'(m8.shutdown));
      check({tag, ".test8"}, 64'(tst8), 64'(m8.test));
      check({tag, ".addr4"}, 64'(fa4), 64'(m4.addr));
      check({tag, ".digits4"}, 64'(dig4), m4.digits);
      check({tag, ".decode4"}, 64'(dec4), 64'(m4.decode));
      check({tag, ".intensity4"}, 64'(int4), 64'(m4.intensity));
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic shift_bits(input logic [31:0] bits, input int n);
      for (int i = n - 1; i >= 0; i--) begin
         din = bits[i];
         tick(4);
         sck = 1'b1;
         tick(4);
         sck = 1'b0;
      end
   endtask

   task automatic send_frame(input logic [31:0] bits, input int n);
      cs = 1'b0;
      tick(5);
      shift_bits(bits, n);
      tick(4);
      cs = 1'b1;
      tick(8);
   endtask

   vec_t tbl[10];

   initial begin
      logic [31:0] rbits;
      int          rn;

      m8 = '{default: '0};
      m4 = '{default: '0};
      tbl[0] = '{32'h0000_0A05, 16, 1, 0};
      tbl[1] = '{32'h0000_0C01, 16, 1, 0};
      tbl[2] = '{32'h0000_0B07, 16, 1, 0};
      tbl[3] = '{32'h0000_0312, 16, 1, 0};
      tbl[4] = '{32'h0000_01FF,  9, 0, 1};
      tbl[5] = '{32'h0000_0A03, 16, 1, 0};
      tbl[6] = '{32'h000F_0F01, 20, 1, 0};
      tbl[7] = '{32'h0000_0755, 16, 1, 0};
      tbl[8] = '{32'h0000_0D77, 16, 1, 0};
      tbl[9] = '{32'h0000_0000, 16, 1, 0};

      tick(4);
      check_state("reset");
      reset = 1'b1;
      tick(10);

      // sck activity with cs high must not register anything.
      for (int i = 0; i < 5; i++) begin
         din = 1'b1;
         sck = 1'b1;
         tick(4);
         sck = 1'b0;
         tick(4);
      end
      check_state("sck_cs_high");

      for (int i = 0; i < 10; i++) begin
         send_frame(tbl[i].bits, tbl[i].n);
         exp_v += tbl[i].exp_v;
         exp_e += tbl[i].exp_e;
         if (tbl[i].n >= 16) begin
            m8 = apply(m8, tbl[i].bits[15:0], 8);
            m4 = apply(m4, tbl[i].bits[15:0], 4);
         end
         check_state($sformatf("tbl%0d", i));
      end
      check("tbl.scan_limit", 64'(scan8), 64'd7);
      check("tbl.shutdown_n", 64'(shd8), 64'd1);
      check("tbl.digit3", 64'(dig8[23:16]), 64'h12);
      check("tbl.display_test", 64'(tst8), 64'd1);
      check("tbl.digit7", 64'(dig8[55:48]), 64'h55);
      check("tbl.digit4_small", 64'(dig4[31:24]), 64'h0);

      // Last bit's sck edge arrives together with cs rising: still a 16-bit frame.
      cs = 1'b0;
      tick(5);
      check("busy_in_frame", 64'(busy8), 64'd1);
      rbits = 32'h0000_0A0B;
      shift_bits(rbits >> 1, 15);
      din = rbits[0];
      tick(4);
      sck = 1'b1;
      cs  = 1'b1;
      tick(4);
      sck = 1'b0;
      tick(8);
      model_frame(rbits, 16);
      check_state("same_edge");
      check("same_edge.intensity", 64'(int8), 64'hB);

      for (int i = 0; i < 40; i++) begin
         rbits = $urandom;
         rn = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 24)) : 16;
         send_frame(rbits, rn);
         model_frame(rbits, rn);
         check_state($sformatf("rnd%0d", i));
      end

      // Reset mid-frame with cs held low, then cs released afterwards.
      cs = 1'b0;
      tick(5);
      shift_bits(32'hA5, 8);
      reset = 1'b0;
      tick(3);
      reset = 1'b1;
      m8 = '{default: '0};
      m4 = '{default: '0};
      tick(6);
      check_state("rst_mid");
      cs = 1'b1;
      tick(10);
      check_state("rst_release");
      send_frame(32'h0000_0901, 16);
      model_frame(32'h0000_0901, 16);
      check_state("post_rst");
      check("post_rst.decode_mode", 64'(dec8), 64'h01);

      check("valid_err_overlap", 64'(both_cnt), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
